am_inserter: RTL and testbench

Transmit-path alignment-marker stage that sits directly downstream of the 20-lane block distributor. It accepts one group of twenty 66-bit blocks per cycle and forwards it unchanged. After every AM_PERIOD accepted groups it inserts one alignment-marker group: one marker per lane, each carrying that lane's fixed marker bytes and its running BIP. Upstream is stalled for exactly one cycle per marker group.

---
 rtl/am_inserter.sv | 155 +++++++++++++++
 tb/tb_am_inserter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/am_inserter.sv
// Alignment-marker inserter for a 20-lane 66b transmit path.
// Forwards data groups and inserts one marker group every AM_PERIOD groups.
module am_inserter #(
   parameter int LEN_CODED_BLOCK = 66,
   parameter int N_LANES         = 20,
   parameter int AM_PERIOD       = 16383
) (
   input  logic                               i_clock,
   input  logic                               i_reset,
   input  logic                               i_valid,
   input  logic [N_LANES*LEN_CODED_BLOCK-1:0] i_data,
   output logic                               o_ready,
   output logic                               o_valid,
   output logic [N_LANES*LEN_CODED_BLOCK-1:0] o_data,
   output logic                               o_am
);

   localparam int L     = LEN_CODED_BLOCK;
   localparam int W     = N_LANES * L;
   localparam int CNT_W = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);

   typedef enum logic {
      ST_AM   = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      ready_q, ready_d;
   logic                      valid_q, valid_d;
   logic                      am_q, am_d;
   logic [W-1:0]              data_q, data_d;
   logic [N_LANES-1:0][7:0]   bip_q, bip_d;

   // Fixed marker bytes M0..M2 per lane (M4..M6 are their complements).
   function automatic logic [23:0] am_bytes(input int k);
      logic [23:0] m;
      case (k)
         0:       m = 24'hC16821;
         1:       m = 24'h9D718E;
         2:       m = 24'h594BE8;
         3:       m = 24'h4D957B;
         4:       m = 24'hF50709;
         5:       m = 24'hDD14C2;
         6:       m = 24'h9A4A26;
         7:       m = 24'h7B4566;
         8:       m = 24'hA02476;
         9:       m = 24'h68C9FB;
         10:      m = 24'hFD6C99;
         11:      m = 24'hB99155;
         12:      m = 24'h5CB9B2;
         13:      m = 24'h1AF8BD;
         14:      m = 24'h83C7CA;
         15:      m = 24'h3536CD;
         16:      m = 24'hC4314C;
         17:      m = 24'hADD6B7;
         18:      m = 24'h5F662A;
         19:      m = 24'hC0F0E5;
         default: m = 24'h000000;
      endcase
      return m;
   endfunction

   // BIP3 contribution of one block: payload bit p lands in parity
   // bit (63-p) mod 8; the two header bits fold into bits 3 and 4.
   function automatic logic [7:0] bip_of(input logic [65:0] blk);
      logic [7:0] r;
      r = 8'h00;
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 8; j++) begin
            r[b] = r[b] ^ blk[63 - b - 8*j];
         end
      end
      r[3] = r[3] ^ blk[65];
      r[4] = r[4] ^ blk[64];
      return r;
   endfunction

   // Marker block; parity bit b is carried at block bit 39-b.
   function automatic logic [65:0] marker(
      input logic [23:0] m,
      input logic [7:0]  acc
   );
      logic [7:0] f;
      for (int b = 0; b < 8; b++) begin
         f[7 - b] = acc[b];
      end
      return {2'b10, m, f, ~m, ~f};
   endfunction

   // Next-state, datapath and per-lane parity update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      am_d    = 1'b0;
      data_d  = data_q;
      bip_d   = bip_q;
      unique case (state_q)
         ST_AM: begin
            for (int k = 0; k < N_LANES; k++) begin
               data_d[k*L +: L] = marker(am_bytes(k), bip_q[k]);
               bip_d[k]         = bip_of(data_d[k*L +: L]);
            end
            valid_d = 1'b1;
            am_d    = 1'b1;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (i_valid && ready_q) begin
               data_d  = i_data;
               valid_d = 1'b1;
               for (int k = 0; k < N_LANES; k++) begin
                  bip_d[k] = bip_q[k] ^ bip_of(i_data[k*L +: L]);
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_AM;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
      ready_d = (state_d == ST_DATA);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_AM;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         am_q    <= 1'b0;
         data_q  <= '0;
         bip_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         am_q    <= am_d;
         data_q  <= data_d;
         bip_q   <= bip_d;
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_am    = am_q;
   assign o_data  = data_q;

endmodule

// File: tb/tb_am_inserter.sv
// Bench for am_inserter with AM_PERIOD=4.
// Scoreboard of expected groups built from an independent lane model.
module tb_am_inserter;

   localparam int P  = 4;
   localparam int NL = 20;
   localparam int L  = 66;
   localparam int W  = NL * L;

   logic         clk;
   logic         i_reset;
   logic         i_valid;
   logic [W-1:0] i_data;
   logic         o_ready;
   logic         o_valid;
   logic [W-1:0] o_data;
   logic         o_am;

   am_inserter #(
      .LEN_CODED_BLOCK(L),
      .N_LANES        (NL),
      .AM_PERIOD      (P)
   ) dut (
      .i_clock(clk),
      .i_reset(i_reset),
      .i_valid(i_valid),
      .i_data (i_data),
      .o_ready(o_ready),
      .o_valid(o_valid),
      .o_data (o_data),
      .o_am   (o_am)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic         am;
      logic [W-1:0] d;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_pass = 0;
   int   n_tot  = 0;

   bit       m_am;
   bit       m_ready;
   int       m_cnt;
   logic [7:0] m_acc [NL];

   task automatic chk(string tag, logic [65:0] obs, logic [65:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
   endtask

   task automatic chk_grp(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      int bad;
      bad = 0;
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         for (int k = NL - 1; k >= 0; k--)
            if (obs[k*L +: L] !== exp[k*L +: L]) bad = k;
         $error("FAIL %s lane %0d obs=%h exp=%h", tag, bad,
                obs[bad*L +: L], exp[bad*L +: L]);
      end
   endtask

   function automatic logic [23:0] m_bytes(int k);
      logic [23:0] t [NL];
      t = '{24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
            24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
            24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
            24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};
      return t[k];
   endfunction

   // Parity by transmission index t = 65 - bit position.
   function automatic logic [7:0] m_bip(logic [65:0] blk);
      logic [7:0] r;
      int         b;
      r = 8'h00;
      for (int t = 0; t < 66; t++) begin
         if (t == 0)      b = 3;
         else if (t == 1) b = 4;
         else             b = (t - 2) % 8;
         r[b] = r[b] ^ blk[65 - t];
      end
      return r;
   endfunction

   function automatic logic [65:0] m_marker(int k, logic [7:0] acc);
      logic [65:0] b;
      b[65:64] = 2'b10;
      b[63:40] = m_bytes(k);
      for (int i = 0; i < 8; i++) b[39 - i] = acc[i];
      b[31:8] = ~b[63:40];
      b[7:0]  = ~b[39:32];
      return b;
   endfunction

   function automatic logic [W-1:0] pay(int n);
      logic [W-1:0] g;
      for (int k = 0; k < NL; k++) g[k*L +: L] = {2'b01, n[31:0], k[31:0]};
      return g;
   endfunction

   // One cycle: check ready, drive, advance model, clock, check valid.
   task automatic step(input bit v, input logic [W-1:0] d, output bit acc);
      bit   ev;
      exp_t x;
      chk("o_ready", o_ready, m_ready);
      i_valid = v;
      i_data  = d;
      acc = 0;
      ev  = 0;
      if (m_am) begin
         for (int k = 0; k < NL; k++) begin
            x.d[k*L +: L] = m_marker(k, m_acc[k]);
            m_acc[k] = m_bip(x.d[k*L +: L]);
         end
         x.am = 1'b1;
         sb.push_back(x);
         m_am = 0;
         m_ready = 1;
         ev = 1;
      end else if (v) begin
         x.d  = d;
         x.am = 1'b0;
         sb.push_back(x);
         for (int k = 0; k < NL; k++) m_acc[k] = m_acc[k] ^ m_bip(d[k*L +: L]);
         m_cnt++;
         if (m_cnt == P) begin
            m_cnt = 0;
            m_am = 1;
            m_ready = 0;
         end
         acc = 1;
         ev  = 1;
      end
      @(posedge clk);
      #1;
      chk("o_valid", o_valid, ev);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      i_valid = 1'b0;
      #1;
      chk_grp("rst_o_data", o_data, '0);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_am", o_am, 0);
      chk("rst_o_ready", o_ready, 0);
      sb.delete();
      m_am = 1;
      m_ready = 0;
      m_cnt = 0;
      for (int k = 0; k < NL; k++) m_acc[k] = 8'h00;
      @(posedge clk);
      @(negedge clk);
      i_reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!i_reset && o_valid) begin
         n_tot++;
         assert (sb.size() != 0) n_pass++;
         else $error("FAIL sb_extra obs_am=%b exp=none", o_am);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk_grp("sb_data", o_data, e.d);
            chk("sb_am", o_am, e.am);
         end
      end
   end

   initial begin
      bit acc;
      int n;
      logic [W-1:0] z;
      logic [W-1:0] d1;
      z = '0;
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;

      // Continuous all-zero data
      do_reset();
      step(1, z, acc);
      chk("first_am", o_am, 1);
      chk("m1_lane0", o_data[0 +: L], {2'b10, 64'hC1682100_3E97DEFF});
      chk("m1_lane1", o_data[L +: L], {2'b10, 64'h9D718E00_628E71FF});
      for (int i = 0; i < 5; i++) step(1, z, acc);
      chk("m2_am", o_am, 1);
      chk("m2_lane0", o_data[0 +: L], {2'b10, 64'hC1682110_3E97DEEF});
      for (int i = 0; i < 10; i++) step(1, z, acc);

      // Single header bit on lane 3
      do_reset();
      step(1, z, acc);
      d1 = '0;
      d1[3*L + 65] = 1'b1;
      step(1, d1, acc);
      for (int i = 0; i < 4; i++) step(1, z, acc);
      chk("bit_am", o_am, 1);
      chk("bit_lane3", o_data[3*L + 32 +: 8], 8'h00);
      chk("bit_lane2", o_data[2*L + 32 +: 8], 8'h10);
      chk("bit_lane4", o_data[4*L + 32 +: 8], 8'h10);

      // Gapped input 1,0,0,...
      do_reset();
      n = 0;
      for (int i = 0; i < 30; i++) begin
         step((i % 3) == 0, pay(n), acc);
         if (acc) n++;
      end

      // Continuous counting payloads through marker stalls
      n = 100;
      for (int i = 0; i < 17; i++) begin
         step(1, pay(n), acc);
         if (acc) n++;
      end

      // Asynchronous reset mid-period
      #2;
      do_reset();
      step(0, z, acc);
      chk("rr_am", o_am, 1);
      chk("rr_lane0", o_data[0 +: L], {2'b10, 64'hC1682100_3E97DEFF});
      for (int i = 0; i < 6; i++) begin
         step(1, pay(i + 500), acc);
      end

      @(negedge clk);
      #1;
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
